// File: rtl/frame_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : frame_sequencer
//  Description : APU frame sequencer. Watches a selected DIV bit for falling
//                edges and steps an 8-phase schedule, emitting one-cycle
//                length (256 Hz), sweep (128 Hz) and envelope (64 Hz) ticks.
//                Optional feature macro: FRAME_SEQ_DOUBLE_SPEED_EN adds the
//                double_speed input, which selects div[DIV_BIT+1] instead.
//  Revision    : 1.0 - initial release
// ============================================================================
module frame_sequencer #(
    parameter int DIV_BIT = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       apu_en,
    input  logic [7:0] div,
`ifdef FRAME_SEQ_DOUBLE_SPEED_EN
    input  logic       double_speed,
`endif
    output logic       length_tick,
    output logic       sweep_tick,
    output logic       envelope_tick,
    output logic [2:0] step
);

    logic       w_sel;
    logic       w_edge;
    logic       w_unused_div;
    logic       r_prev_sel;
    logic [2:0] r_step;
    logic       r_length_tick;
    logic       r_sweep_tick;
    logic       r_envelope_tick;

    // Only one or two DIV bits matter; fold the rest so they read as used.
    assign w_unused_div = ^div;

`ifdef FRAME_SEQ_DOUBLE_SPEED_EN
    logic r_double_speed;
    logic w_speed_switch;

    // Remember the previous speed so a switch cycle can be recognised.
    always_ff @(posedge clk) begin
        if (reset) r_double_speed <= 1'b0;
        else       r_double_speed <= double_speed;
    end

    // A speed switch changes which bit is watched; ignore edges that cycle.
    assign w_speed_switch = (double_speed != r_double_speed);
    assign w_sel  = double_speed ? div[DIV_BIT+1] : div[DIV_BIT];
    assign w_edge = r_prev_sel & ~w_sel & apu_en & ~w_speed_switch;
`else
    assign w_sel  = div[DIV_BIT];
    assign w_edge = r_prev_sel & ~w_sel & apu_en;
`endif

    // Track the selected bit every cycle, even while the APU is off, so
    // power-on never sees a stale high value.
    always_ff @(posedge clk) begin
        if (reset) r_prev_sel <= 1'b0;
        else       r_prev_sel <= w_sel;
    end

    // Execute the current step on an edge event and advance; ticks are
    // registered so they appear the cycle after the edge for exactly one cycle.
    always_ff @(posedge clk) begin
        if (reset || !apu_en) begin
            r_step          <= 3'd0;
            r_length_tick   <= 1'b0;
            r_sweep_tick    <= 1'b0;
            r_envelope_tick <= 1'b0;
        end else if (w_edge) begin
            // Even steps clock length; steps 2 and 6 also clock sweep;
            // step 7 clocks the envelopes.
            r_length_tick   <= ~r_step[0];
            r_sweep_tick    <= r_step[1] & ~r_step[0];
            r_envelope_tick <= (r_step == 3'd7);
            r_step          <= r_step + 3'd1;
        end else begin
            r_length_tick   <= 1'b0;
            r_sweep_tick    <= 1'b0;
            r_envelope_tick <= 1'b0;
        end
    end

    assign length_tick   = r_length_tick;
    assign sweep_tick    = r_sweep_tick;
    assign envelope_tick = r_envelope_tick;
    assign step          = r_step;

endmodule
`default_nettype wire

// File: tb/tb_frame_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_frame_sequencer
//  Description : Directed self-checking bench for frame_sequencer.
//                Exercises FRAME_SEQ_DOUBLE_SPEED_EN paths when defined.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_frame_sequencer;

    logic       clk;
    logic       reset;
    logic       apu_en;
    logic [7:0] div;
    logic       length_tick;
    logic       sweep_tick;
    logic       envelope_tick;
    logic [2:0] step;
`ifdef FRAME_SEQ_DOUBLE_SPEED_EN
    logic       double_speed;
`endif

    int checks;
    int errors;

    frame_sequencer #(.DIV_BIT(4)) dut (
        .clk           (clk),
        .reset         (reset),
        .apu_en        (apu_en),
        .div           (div),
`ifdef FRAME_SEQ_DOUBLE_SPEED_EN
        .double_speed  (double_speed),
`endif
        .length_tick   (length_tick),
        .sweep_tick    (sweep_tick),
        .envelope_tick (envelope_tick),
        .step          (step)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock; outputs are sampled 1 ns after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Raise div[4] for a cycle, then lower it; after return the edge's ticks
    // are visible.
    task automatic fall_edge();
        div = div | 8'h10;
        tick();
        div = div & 8'hEF;
        tick();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        checks++;
        if (step !== 3'd0) begin
            errors++;
            $display("FAIL reset_step got=%0d exp=0", step);
        end
        checks++;
        if ({length_tick, sweep_tick, envelope_tick} !== 3'b000) begin
            errors++;
            $display("FAIL reset_ticks got=%b exp=000", {length_tick, sweep_tick, envelope_tick});
        end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_schedule();
        logic [7:0] exp_len;
        logic [7:0] exp_swp;
        logic [7:0] exp_env;
        logic [2:0] exp_step;
        exp_len = 8'b0101_0101;
        exp_swp = 8'b0100_0100;
        exp_env = 8'b1000_0000;
        apu_en = 1'b1;
        tick();
        for (int i = 0; i < 8; i++) begin
            fall_edge();
            exp_step = 3'(i + 1);
            checks++;
            if ({length_tick, sweep_tick, envelope_tick} !== {exp_len[i], exp_swp[i], exp_env[i]}) begin
                errors++;
                $display("FAIL sched_ticks step=%0d got=%b exp=%b", i,
                         {length_tick, sweep_tick, envelope_tick},
                         {exp_len[i], exp_swp[i], exp_env[i]});
            end
            checks++;
            if (step !== exp_step) begin
                errors++;
                $display("FAIL sched_step after=%0d got=%0d exp=%0d", i, step, exp_step);
            end
            tick();
            checks++;
            if ({length_tick, sweep_tick, envelope_tick} !== 3'b000) begin
                errors++;
                $display("FAIL sched_width step=%0d got=%b exp=000", i,
                         {length_tick, sweep_tick, envelope_tick});
            end
        end
    endtask

    task automatic test_no_edge();
        logic [7:0] pattern [8];
        pattern = '{8'h08, 8'h00, 8'h20, 8'h00, 8'h10, 8'h18, 8'h30, 8'h10};
        for (int i = 0; i < 8; i++) begin
            div = pattern[i];
            tick();
            checks++;
            if ({length_tick, sweep_tick, envelope_tick, step} !== 6'b000_000) begin
                errors++;
                $display("FAIL no_edge idx=%0d got=%b/%0d exp=000/0", i,
                         {length_tick, sweep_tick, envelope_tick}, step);
            end
        end
    endtask

    task automatic test_apu_off();
        for (int i = 0; i < 5; i++) fall_edge();
        checks++;
        if (step !== 3'd5) begin
            errors++;
            $display("FAIL off_pre_step got=%0d exp=5", step);
        end
        apu_en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if ({length_tick, sweep_tick, envelope_tick, step} !== 6'b000_000) begin
                errors++;
                $display("FAIL off_forced cyc=%0d got=%b/%0d exp=000/0", i,
                         {length_tick, sweep_tick, envelope_tick}, step);
            end
        end
        apu_en = 1'b1;
        tick();
        fall_edge();
        checks++;
        if ({length_tick, sweep_tick, envelope_tick} !== 3'b100 || step !== 3'd1) begin
            errors++;
            $display("FAIL off_first_edge got=%b/%0d exp=100/1",
                     {length_tick, sweep_tick, envelope_tick}, step);
        end
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 5; i++) fall_edge();
        fall_edge();
        checks++;
        if ({length_tick, sweep_tick, envelope_tick} !== 3'b110 || step !== 3'd7) begin
            errors++;
            $display("FAIL mid_step6 got=%b/%0d exp=110/7",
                     {length_tick, sweep_tick, envelope_tick}, step);
        end
        reset = 1'b1;
        tick();
        checks++;
        if ({length_tick, sweep_tick, envelope_tick} !== 3'b000 || step !== 3'd0) begin
            errors++;
            $display("FAIL mid_reset got=%b/%0d exp=000/0",
                     {length_tick, sweep_tick, envelope_tick}, step);
        end
        reset = 1'b0;
        tick();
        fall_edge();
        checks++;
        if ({length_tick, sweep_tick, envelope_tick} !== 3'b100 || step !== 3'd1) begin
            errors++;
            $display("FAIL mid_after got=%b/%0d exp=100/1",
                     {length_tick, sweep_tick, envelope_tick}, step);
        end
    endtask

    task automatic test_off_edge();
        apu_en = 1'b0;
        div    = 8'h10;
        tick();
        tick();
        div = 8'h00;
        tick();
        apu_en = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick();
            checks++;
            if ({length_tick, sweep_tick, envelope_tick, step} !== 6'b000_000) begin
                errors++;
                $display("FAIL off_edge cyc=%0d got=%b/%0d exp=000/0", i,
                         {length_tick, sweep_tick, envelope_tick}, step);
            end
        end
        // Edge arriving in the very cycle the APU powers on counts as step 0.
        apu_en = 1'b0;
        div    = 8'h10;
        tick();
        apu_en = 1'b1;
        div    = 8'h00;
        tick();
        checks++;
        if ({length_tick, sweep_tick, envelope_tick} !== 3'b100 || step !== 3'd1) begin
            errors++;
            $display("FAIL poweron_edge got=%b/%0d exp=100/1",
                     {length_tick, sweep_tick, envelope_tick}, step);
        end
    endtask

`ifdef FRAME_SEQ_DOUBLE_SPEED_EN
    task automatic test_double_speed();
        reset = 1'b1;
        div   = 8'h00;
        tick();
        reset        = 1'b0;
        double_speed = 1'b1;
        tick();
        tick();
        fall_edge();
        tick();
        checks++;
        if ({length_tick, sweep_tick, envelope_tick, step} !== 6'b000_000) begin
            errors++;
            $display("FAIL ds_div4_ignored got=%b/%0d exp=000/0",
                     {length_tick, sweep_tick, envelope_tick}, step);
        end
        div = 8'h20;
        tick();
        div = 8'h00;
        tick();
        checks++;
        if ({length_tick, sweep_tick, envelope_tick} !== 3'b100 || step !== 3'd1) begin
            errors++;
            $display("FAIL ds_div5_edge got=%b/%0d exp=100/1",
                     {length_tick, sweep_tick, envelope_tick}, step);
        end
        double_speed = 1'b0;
        div          = 8'h10;
        tick();
        tick();
        double_speed = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick();
            checks++;
            if ({length_tick, sweep_tick, envelope_tick} !== 3'b000 || step !== 3'd1) begin
                errors++;
                $display("FAIL ds_switch cyc=%0d got=%b/%0d exp=000/1", i,
                         {length_tick, sweep_tick, envelope_tick}, step);
            end
        end
    endtask
`endif

    initial begin
        checks = 0;
        errors = 0;
        reset  = 1'b1;
        apu_en = 1'b0;
        div    = 8'h00;
`ifdef FRAME_SEQ_DOUBLE_SPEED_EN
        double_speed = 1'b0;
`endif
        test_reset();
        test_schedule();
        test_no_edge();
        test_apu_off();
        test_reset_mid();
        test_off_edge();
`ifdef FRAME_SEQ_DOUBLE_SPEED_EN
        test_double_speed();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
